sdram_bank_timing_monitor: RTL and testbench
============================================

SDRAM_BANK_TIMING_MONITOR -- requirements
Module: sdram_bank_timing_monitor

Interface
REQ-001 Parameter BA_WIDTH, 3, bank address width; NUM_BANKS = 2**BA_WIDTH.
REQ-002 Parameter T_WR, 4, write-recovery cycles (WR to PRE, same bank), range 1..15.
REQ-003 Parameter T_RP, 3, precharge cycles (PRE to ACT, same bank), range 1..15.
REQ-004 Parameter CNT_W, 8, violation counter width.
REQ-005 clk  input  1  sole clock, all state on posedge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 cmd  input  2  command code (NOP, PRE, WR, ACT), sampled every cycle.
REQ-008 bank  input  BA_WIDTH  target bank of cmd; ignored for NOP.
REQ-009 viol  output  1  one-cycle pulse, registered, per detected violation.
REQ-010 viol_type  output  2  NONE/WR2PRE/PRE2ACT; NONE when viol=0.
REQ-011 viol_bank  output  BA_WIDTH  bank of the violation; 0 when viol=0.
REQ-012 viol_cnt  output  CNT_W  saturating total violation count.
REQ-013 wr_busy  output  NUM_BANKS  bit b high while PRE to bank b is illegal.

Function
REQ-014 Per bank: wr_cnt (4 bits) and rp_cnt (4 bits), both decrementing by 1 per cycle when nonzero.
REQ-015 WR to bank b in cycle t loads wr_cnt[b]=T_WR; PRE to bank b is illegal in cycles t+1..t+T_WR, legal from t+T_WR+1.
REQ-016 PRE to bank b in cycle t loads rp_cnt[b]=T_RP; ACT to bank b is illegal in cycles t+1..t+T_RP.
REQ-017 PRE to bank b when wr_cnt[b]!=0 -> viol=1, viol_type=WR2PRE, viol_bank=b in cycle t+1.
REQ-018 ACT to bank b when rp_cnt[b]!=0 -> viol=1, viol_type=PRE2ACT, viol_bank=b in cycle t+1.
REQ-019 An illegal PRE still loads rp_cnt[b]; WR while wr_cnt[b]!=0 is legal and reloads T_WR.
REQ-020 Commands to bank b never affect counters of any other bank.
REQ-021 Load takes priority over decrement in the same cycle.
REQ-022 viol_cnt increments on each viol pulse and holds at 2**CNT_W-1 with no wrap.
REQ-023 wr_busy[b] = (wr_cnt[b]!=0), combinational from registered state.
REQ-024 NOP produces no state change beyond decrements.

Reset
REQ-025 rstn low asynchronously clears all counters, viol, viol_type, viol_bank, viol_cnt and wr_busy to 0.
REQ-026 A command in the cycle rstn deasserts is evaluated normally; assertion mid-operation discards all pending windows and any pending viol.

Configuration
REQ-027 With SDRAM_MON_ASSERT_EN defined, the module embeds concurrent assertions (default clocking posedge clk, disable iff !rstn): every WR to nd_bank is followed by no PRE to nd_bank for T_WR cycles, likewise PRE->ACT for T_RP, plus a cover of each viol_type.
REQ-028 Without SDRAM_MON_ASSERT_EN, no assertion or cover code exists and RTL behaviour is identical.

Structure
REQ-029 Package sdram_mon_pkg holds cmd codes (NOP=2'b00, PRE=2'b01, WR=2'b10, ACT=2'b11) and the viol_type enum (NONE=0, WR2PRE=1, PRE2ACT=2).
REQ-030 Sub-module sdram_bank_timer (one per bank, generate loop) holds wr_cnt/rp_cnt and their load/decrement logic.

Verification (T_WR=4, T_RP=3, BA_WIDTH=3)
REQ-031 WR bank 2 at cycle 2, PRE bank 2 at cycle 6 -> viol=1, WR2PRE, viol_bank=2 at cycle 7; viol_cnt=1.
REQ-032 WR bank 2 at cycle 2, PRE bank 2 at cycle 7 -> no viol; wr_busy[2] high cycles 3..6 only.
REQ-033 WR bank 1 at 2, PRE bank 5 at 3 -> no viol; PRE bank 1 at 3 -> WR2PRE, viol_bank=1 at 4.
REQ-034 PRE bank 0 at 4, ACT bank 0 at 6 -> PRE2ACT at 7; ACT bank 0 at 8 -> no viol.
REQ-035 WR bank 3 at 2, rstn low at 3, released at 4, PRE bank 3 at 5 -> no viol, viol_cnt=0.
REQ-036 CNT_W=2, five consecutive violations -> viol_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/sdram_mon_pkg.sv
// Shared command codes, violation types and counter sizing for the SDRAM bank timing monitor.
package sdram_mon_pkg;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    PRE = 2'b01,
    WR  = 2'b10,
    ACT = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    WR2PRE  = 2'd1,
    PRE2ACT = 2'd2
  } viol_type_e;

  localparam int unsigned TCNT_W = 4;

endpackage

// File: rtl/sdram_bank_timer.sv
// Per-bank write-recovery and precharge countdown timers.
module sdram_bank_timer
  import sdram_mon_pkg::*;
#(
  parameter int unsigned T_WR = 4,
  parameter int unsigned T_RP = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic wr_ld_i,
  input  logic pre_ld_i,
  output logic wr_busy_o,
  output logic rp_busy_o
);

  localparam logic [TCNT_W-1:0] WR_LOAD = TCNT_W'(T_WR);
  localparam logic [TCNT_W-1:0] RP_LOAD = TCNT_W'(T_RP);
  localparam logic [TCNT_W-1:0] ONE     = TCNT_W'(1);

  logic [TCNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [TCNT_W-1:0] rp_cnt_q, rp_cnt_d;

  // A load wins over the decrement so a back-to-back command restarts the full window.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rp_cnt_d = rp_cnt_q;
    if (wr_ld_i)
      wr_cnt_d = WR_LOAD;
    else if (wr_cnt_q != '0)
      wr_cnt_d = wr_cnt_q - ONE;
    if (pre_ld_i)
      rp_cnt_d = RP_LOAD;
    else if (rp_cnt_q != '0)
      rp_cnt_d = rp_cnt_q - ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q <= '0;
      rp_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rp_cnt_q <= rp_cnt_d;
    end
  end

  assign wr_busy_o = (wr_cnt_q != '0);
  assign rp_busy_o = (rp_cnt_q != '0);

endmodule

// File: rtl/sdram_bank_timing_monitor.sv
// Flags WR->PRE (tWR) and PRE->ACT (tRP) violations per SDRAM bank.
// Define SDRAM_MON_ASSERT_EN to embed protocol assertions and violation covers.
module sdram_bank_timing_monitor
  import sdram_mon_pkg::*;
#(
  parameter int unsigned BA_WIDTH = 3,
  parameter int unsigned T_WR     = 4,
  parameter int unsigned T_RP     = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [1:0]                 cmd,
  input  logic [BA_WIDTH-1:0]        bank,
  output logic                       viol,
  output logic [1:0]                 viol_type,
  output logic [BA_WIDTH-1:0]        viol_bank,
  output logic [CNT_W-1:0]           viol_cnt,
  output logic [(2**BA_WIDTH)-1:0]   wr_busy
);

  localparam int unsigned NUM_BANKS = 2**BA_WIDTH;

  logic [NUM_BANKS-1:0] wr_ld, pre_ld;
  logic [NUM_BANKS-1:0] wr_busy_w, rp_busy_w;

  logic                viol_q, viol_d;
  viol_type_e          viol_type_q, viol_type_d;
  logic [BA_WIDTH-1:0] viol_bank_q, viol_bank_d;
  logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;

  always_comb begin
    wr_ld  = '0;
    pre_ld = '0;
    if (cmd == WR)
      wr_ld[bank] = 1'b1;
    if (cmd == PRE)
      pre_ld[bank] = 1'b1;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sdram_bank_timer #(
      .T_WR(T_WR),
      .T_RP(T_RP)
    ) u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .wr_ld_i  (wr_ld[b]),
      .pre_ld_i (pre_ld[b]),
      .wr_busy_o(wr_busy_w[b]),
      .rp_busy_o(rp_busy_w[b])
    );
  end

  // Only one command per cycle, so at most one violation can be raised.
  always_comb begin
    viol_d      = 1'b0;
    viol_type_d = NONE;
    viol_bank_d = '0;
    if (cmd == PRE && wr_busy_w[bank]) begin
      viol_d      = 1'b1;
      viol_type_d = WR2PRE;
      viol_bank_d = bank;
    end else if (cmd == ACT && rp_busy_w[bank]) begin
      viol_d      = 1'b1;
      viol_type_d = PRE2ACT;
      viol_bank_d = bank;
    end
    viol_cnt_d = viol_cnt_q;
    if (viol_d && viol_cnt_q != '1)
      viol_cnt_d = viol_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      viol_q      <= 1'b0;
      viol_type_q <= NONE;
      viol_bank_q <= '0;
      viol_cnt_q  <= '0;
    end else begin
      viol_q      <= viol_d;
      viol_type_q <= viol_type_d;
      viol_bank_q <= viol_bank_d;
      viol_cnt_q  <= viol_cnt_d;
    end
  end

  assign viol      = viol_q;
  assign viol_type = viol_type_q;
  assign viol_bank = viol_bank_q;
  assign viol_cnt  = viol_cnt_q;
  assign wr_busy   = wr_busy_w;

`ifdef SDRAM_MON_ASSERT_EN
  default clocking cb_mon @(posedge clk); endclocking
  default disable iff (!rstn);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_assert
    a_wr2pre: assert property (
      (cmd == WR && bank == BA_WIDTH'(b)) |=> !(cmd == PRE && bank == BA_WIDTH'(b)) [*T_WR]);
    a_pre2act: assert property (
      (cmd == PRE && bank == BA_WIDTH'(b)) |=> !(cmd == ACT && bank == BA_WIDTH'(b)) [*T_RP]);
  end

  c_wr2pre:  cover property (viol && viol_type == WR2PRE);
  c_pre2act: cover property (viol && viol_type == PRE2ACT);
`endif

endmodule

// File: tb/tb_sdram_bank_timing_monitor.sv
// Self-checking bench: fixed vector table, corner-case sequences and random traffic vs. a cycle-stamp model.
module tb_sdram_bank_timing_monitor;
  import sdram_mon_pkg::*;

  localparam int BA_WIDTH = 3;
  localparam int T_WR     = 4;
  localparam int T_RP     = 3;
  localparam int NB       = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [2:0] bank = 3'd0;

  logic       viol, viol2;
  logic [1:0] vtype, vtype2;
  logic [2:0] vbank, vbank2;
  logic [7:0] vcnt;
  logic [1:0] vcnt2;
  logic [7:0] busy, busy2;

  always #5 clk = ~clk;

  sdram_bank_timing_monitor #(.BA_WIDTH(BA_WIDTH), .T_WR(T_WR), .T_RP(T_RP), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .cmd(cmd), .bank(bank), .viol(viol), .viol_type(vtype),
    .viol_bank(vbank), .viol_cnt(vcnt), .wr_busy(busy));

  sdram_bank_timing_monitor #(.BA_WIDTH(BA_WIDTH), .T_WR(T_WR), .T_RP(T_RP), .CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .cmd(cmd), .bank(bank), .viol(viol2), .viol_type(vtype2),
    .viol_bank(vbank2), .viol_cnt(vcnt2), .wr_busy(busy2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the cycle of the last WR/PRE per bank.
  int         cyc;
  int         last_wr[NB];
  int         last_pre[NB];
  int         m_cnt;
  logic       m_viol;
  logic [1:0] m_type;
  logic [2:0] m_bank;

  function automatic void model_reset();
    cyc = 0;
    m_cnt = 0;
    m_viol = 1'b0;
    m_type = 2'd0;
    m_bank = 3'd0;
    for (int b = 0; b < NB; b++) begin
      last_wr[b]  = -100;
      last_pre[b] = -100;
    end
  endfunction

  function automatic void model_step(input logic [1:0] c, input logic [2:0] b);
    int dw, dp;
    dw = cyc - last_wr[b];
    dp = cyc - last_pre[b];
    m_viol = 1'b0;
    m_type = 2'd0;
    m_bank = 3'd0;
    if (c == 2'b01 && dw >= 1 && dw <= T_WR) begin
      m_viol = 1'b1; m_type = 2'd1; m_bank = b;
    end
    if (c == 2'b11 && dp >= 1 && dp <= T_RP) begin
      m_viol = 1'b1; m_type = 2'd2; m_bank = b;
    end
    if (m_viol) m_cnt++;
    if (c == 2'b10) last_wr[b] = cyc;
    if (c == 2'b01) last_pre[b] = cyc;
    cyc++;
  endfunction

  function automatic logic [7:0] model_busy();
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < NB; b++)
      r[b] = (cyc - last_wr[b] >= 1) && (cyc - last_wr[b] <= T_WR);
    return r;
  endfunction

  task automatic tick(input logic [1:0] c, input logic [2:0] b);
    cmd  = c;
    bank = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_check(input logic [1:0] c, input logic [2:0] b);
    model_step(c, b);
    tick(c, b);
    check("viol",      viol,  m_viol);
    check("viol_type", vtype, m_type);
    check("viol_bank", vbank, m_bank);
    check("viol_cnt",  vcnt,  (m_cnt > 255) ? 255 : m_cnt);
    check("viol_cnt2", vcnt2, (m_cnt > 3) ? 3 : m_cnt);
    check("wr_busy",   busy,  model_busy());
  endtask

  // Called at a negedge; asserts reset between edges, checks async clear, releases at a negedge.
  task automatic do_reset();
    rstn = 1'b0;
    cmd  = 2'b00;
    #1;
    check("rst_viol",  viol,  0);
    check("rst_type",  vtype, 0);
    check("rst_bank",  vbank, 0);
    check("rst_cnt",   vcnt,  0);
    check("rst_cnt2",  vcnt2, 0);
    check("rst_busy",  busy,  0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] c;
    logic [2:0] b;
    logic       ev;
    logic [1:0] et;
    logic [2:0] eb;
    logic [7:0] ecnt;
    logic [1:0] ecnt2;
    logic [7:0] ebusy;
  } vec_t;

  vec_t tbl[$];
  int   exp2_seq[5] = '{1, 2, 3, 3, 3};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Each row: command in cycle i, expected outputs in cycle i+1.
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd0, 2'd0, 8'h00});
    tbl.push_back('{2'b10, 3'd2, 1'b0, 2'd0, 3'd0, 8'd0, 2'd0, 8'h04});
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd0, 2'd0, 8'h04});
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd0, 2'd0, 8'h04});
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd0, 2'd0, 8'h04});
    tbl.push_back('{2'b01, 3'd2, 1'b1, 2'd1, 3'd2, 8'd1, 2'd1, 8'h00});
    tbl.push_back('{2'b11, 3'd2, 1'b1, 2'd2, 3'd2, 8'd2, 2'd2, 8'h00});
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd2, 2'd2, 8'h00});
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd2, 2'd2, 8'h00});
    tbl.push_back('{2'b11, 3'd2, 1'b0, 2'd0, 3'd0, 8'd2, 2'd2, 8'h00});
    tbl.push_back('{2'b10, 3'd1, 1'b0, 2'd0, 3'd0, 8'd2, 2'd2, 8'h02});
    tbl.push_back('{2'b01, 3'd5, 1'b0, 2'd0, 3'd0, 8'd2, 2'd2, 8'h02});
    tbl.push_back('{2'b01, 3'd1, 1'b1, 2'd1, 3'd1, 8'd3, 2'd3, 8'h02});
    tbl.push_back('{2'b11, 3'd5, 1'b1, 2'd2, 3'd5, 8'd4, 2'd3, 8'h02});
    tbl.push_back('{2'b10, 3'd1, 1'b0, 2'd0, 3'd0, 8'd4, 2'd3, 8'h02});
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd4, 2'd3, 8'h02});
    tbl.push_back('{2'b11, 3'd5, 1'b0, 2'd0, 3'd0, 8'd4, 2'd3, 8'h02});
    tbl.push_back('{2'b01, 3'd1, 1'b1, 2'd1, 3'd1, 8'd5, 2'd3, 8'h02});
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd5, 2'd3, 8'h00});
    tbl.push_back('{2'b11, 3'd1, 1'b1, 2'd2, 3'd1, 8'd6, 2'd3, 8'h00});
    tbl.push_back('{2'b00, 3'd0, 1'b0, 2'd0, 3'd0, 8'd6, 2'd3, 8'h00});

    @(negedge clk);
    do_reset();
    foreach (tbl[i]) begin
      tick(tbl[i].c, tbl[i].b);
      check($sformatf("tbl%0d_viol", i),  viol,  tbl[i].ev);
      check($sformatf("tbl%0d_type", i),  vtype, tbl[i].et);
      check($sformatf("tbl%0d_bank", i),  vbank, tbl[i].eb);
      check($sformatf("tbl%0d_cnt", i),   vcnt,  tbl[i].ecnt);
      check($sformatf("tbl%0d_cnt2", i),  vcnt2, tbl[i].ecnt2);
      check($sformatf("tbl%0d_busy", i),  busy,  tbl[i].ebusy);
    end

    // Five back-to-back violations: narrow counter must saturate at 3.
    do_reset();
    step_check(2'b10, 3'd0);
    step_check(2'b01, 3'd0);
    check("sat_viol0", viol2, 1);
    check("sat_cnt0",  vcnt2, exp2_seq[0]);
    step_check(2'b11, 3'd0);
    check("sat_viol1", viol2, 1);
    check("sat_cnt1",  vcnt2, exp2_seq[1]);
    step_check(2'b01, 3'd0);
    check("sat_viol2", viol2, 1);
    check("sat_cnt2",  vcnt2, exp2_seq[2]);
    step_check(2'b11, 3'd0);
    check("sat_viol3", viol2, 1);
    check("sat_cnt3",  vcnt2, exp2_seq[3]);
    step_check(2'b11, 3'd0);
    check("sat_viol4", viol2, 1);
    check("sat_cnt4",  vcnt2, exp2_seq[4]);

    // Reset mid-window discards the pending tWR window and any pending pulse.
    do_reset();
    step_check(2'b10, 3'd3);
    check("rstwin_busy", busy, 8'h08);
    do_reset();
    tick(2'b01, 3'd3);
    check("rstwin_viol", viol, 0);
    check("rstwin_cnt",  vcnt, 0);
    model_step(2'b01, 3'd3);

    // Reset with a violation about to be registered.
    do_reset();
    step_check(2'b01, 3'd6);
    cmd = 2'b11; bank = 3'd6;
    do_reset();
    check("rstpend_viol", viol, 0);

    // Random traffic, banks biased low so windows collide often.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [1:0] rc;
      logic [2:0] rb;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        rc = 2'($urandom_range(0, 3));
        rb = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
        step_check(rc, rb);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
